// File: rtl/fp_mul_pkg.sv
// Shared definitions for the single-precision multiply controller:
// FSM state encoding, IEEE-754 constants, flag bit positions, result payload.
package fp_mul_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned EXPS_W = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FLAG_W = 4;

  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] INF_MAG = 32'h7F80_0000;

  localparam int unsigned INVALID   = 3;
  localparam int unsigned OVERFLOW  = 2;
  localparam int unsigned UNDERFLOW = 1;
  localparam int unsigned INEXACT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Result word plus its exception flags
  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic [FLAG_W-1:0] flags;
  } fp_res_t;

  // Build a flag vector in {invalid, overflow, underflow, inexact} order
  function automatic logic [FLAG_W-1:0] mk_flags(input logic inv, input logic ovf,
                                                 input logic unf, input logic inx);
    logic [FLAG_W-1:0] f;
    f            = '0;
    f[INVALID]   = inv;
    f[OVERFLOW]  = ovf;
    f[UNDERFLOW] = unf;
    f[INEXACT]   = inx;
    return f;
  endfunction

endpackage

// File: rtl/fp_multiplier.sv
// Combinational 24x24 unsigned mantissa array returning the raw 48-bit product.
// Ports: a, b - 24-bit mantissas (hidden bit included); p - 48-bit product.
module fp_multiplier
  import fp_mul_pkg::*;
(
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/fp_mul_ctrl.sv
// IEEE-754 single-precision multiply unit built around a multicycle mantissa
// array: classifies operands, holds them for SETTLE_CYCLES, then normalizes,
// rounds to nearest-even and emits result plus flags over valid/ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b operand
// side; out_valid/out_ready/out_result/out_flags result side; busy = not idle.
module fp_mul_ctrl
  import fp_mul_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0]   prod_q, prod_d, mul_p;
  logic                out_valid_d;
  logic [WORD_W-1:0]   out_result_d;
  logic [FLAG_W-1:0]   out_flags_d;

  // Array fed only from the operand registers so it sees stable inputs
  fp_multiplier u_mul (
    .a ({1'b1, a_q[FRAC_W-1:0]}),
    .b ({1'b1, b_q[FRAC_W-1:0]}),
    .p (mul_p)
  );

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign busy     = (state_q != ST_IDLE);

  // Operand classification on the incoming pair; denormals count as zero
  logic    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, in_sign, special;
  fp_res_t spec_res;

  always_comb begin
    a_zero  = (in_a[30:23] == '0);
    b_zero  = (in_b[30:23] == '0);
    a_inf   = (in_a[30:23] == EXP_W'(EXP_MAX)) && (in_a[FRAC_W-1:0] == '0);
    b_inf   = (in_b[30:23] == EXP_W'(EXP_MAX)) && (in_b[FRAC_W-1:0] == '0);
    a_nan   = (in_a[30:23] == EXP_W'(EXP_MAX)) && (in_a[FRAC_W-1:0] != '0);
    b_nan   = (in_b[30:23] == EXP_W'(EXP_MAX)) && (in_b[FRAC_W-1:0] != '0);
    in_sign = in_a[31] ^ in_b[31];
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    spec_res.result = {in_sign, 31'd0};
    spec_res.flags  = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res.result = QNAN;
      spec_res.flags  = mk_flags(1'b1, 1'b0, 1'b0, 1'b0);
    end else if (a_inf || b_inf) begin
      spec_res.result = {in_sign, INF_MAG[30:0]};
    end
  end

  // Normalize, round to nearest-even, range check from the captured product
  logic signed [EXPS_W-1:0] e_base, e_norm, e_fin;
  logic [FRAC_W-1:0]        mant;
  logic [MANT_W-1:0]        mant_rnd;
  logic                     guard, sticky, round_up, res_sign;
  fp_res_t                  norm_res;

  always_comb begin
    res_sign = a_q[31] ^ b_q[31];
    e_base   = $signed(EXPS_W'(a_q[30:23]) + EXPS_W'(b_q[30:23]) - EXPS_W'(BIAS));
    if (prod_q[47]) begin
      mant   = prod_q[46:24];
      guard  = prod_q[23];
      sticky = |prod_q[22:0];
      e_norm = e_base + 10'sd1;
    end else begin
      mant   = prod_q[45:23];
      guard  = prod_q[22];
      sticky = |prod_q[21:0];
      e_norm = e_base;
    end
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + MANT_W'(round_up);
    // A carry out of the fraction leaves 1.0, so the fraction wraps to zero
    e_fin    = mant_rnd[FRAC_W] ? (e_norm + 10'sd1) : e_norm;
    norm_res.result = {res_sign, e_fin[EXP_W-1:0], mant_rnd[FRAC_W-1:0]};
    norm_res.flags  = mk_flags(1'b0, 1'b0, 1'b0, guard | sticky);
    if (e_fin >= $signed(EXPS_W'(EXP_MAX))) begin
      norm_res.result = {res_sign, INF_MAG[30:0]};
      norm_res.flags  = mk_flags(1'b0, 1'b1, 1'b0, 1'b1);
    end else if (e_fin <= 10'sd0) begin
      norm_res.result = {res_sign, 31'd0};
      norm_res.flags  = mk_flags(1'b0, 1'b0, 1'b1, 1'b1);
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    prod_d       = prod_q;
    out_valid_d  = out_valid;
    out_result_d = out_result;
    out_flags_d  = out_flags;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d = in_a;
          b_d = in_b;
          if (special) begin
            out_result_d = spec_res.result;
            out_flags_d  = spec_res.flags;
            out_valid_d  = 1'b1;
            state_d      = ST_DONE;
          end else begin
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          prod_d  = mul_p;
          state_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ROUND: begin
        out_result_d = norm_res.result;
        out_flags_d  = norm_res.flags;
        out_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      out_valid  <= out_valid_d;
      out_result <= out_result_d;
      out_flags  <= out_flags_d;
    end
  end

endmodule

// File: doc/fp_mul_ctrl.md
# fp_mul_ctrl

Sequencing controller for the combinational 24x24 mantissa array `fp_multiplier`, which returns a raw 48-bit product. It turns that array into a complete IEEE-754 single-precision multiply unit with valid/ready handshakes on both sides. The controller:
- classifies operands;
- holds operands stable for a programmable multicycle settle window;
- normalizes, rounds to nearest-even and assembles the result and exception flags.

It sits between the operand issue logic and the result writeback.

## Interface
- `SETTLE_CYCLES`, 2: cycles operands are held before the array product is sampled; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller can accept; 1 only in IDLE with `rst`=0.
- `in_a`, `in_b`  in  32  IEEE-754 single operands.
- `out_valid`  out  1  result valid; 1 only in DONE.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  32  IEEE-754 single product.
- `out_flags`  out  4  {invalid, overflow, underflow, inexact}.
- `busy`  out  1  state != IDLE.

## Operation
- **States.** IDLE, SETTLE, ROUND, DONE.
- **Transitions.**
  - **IDLE.** On `in_valid && in_ready`, register the operands and classify them:
    - Special path → DONE.
    - Otherwise → SETTLE, with the counter loaded to `SETTLE_CYCLES-1`.
  - **SETTLE.** Decrement the counter. At 0, register the array output into `prod_q[47:0]` and go to ROUND.
  - **ROUND.** Register `out_result`/`out_flags` and go to DONE.
  - **DONE.** Hold until `out_ready`, then go to IDLE. There is no overlap: a new operand pair cannot be accepted in the same cycle a result leaves.
- **Input classification.**
  - Sign is `a[31]^b[31]`.
  - exp==0 means zero: denormal inputs are flushed to zero, with no flag.
- **Special path results.**
  - Any NaN, or inf×0 → 0x7FC00000, invalid=1.
  - inf × nonzero → sign|0x7F800000, no flags.
  - zero × finite → sign|0x00000000, no flags.
- **Normal path: normalization.** Use a 10-bit signed exponent, e = ea + eb − 127.
  - If `prod_q[47]`: mant=`prod_q[46:24]`, guard=`prod_q[23]`, sticky=|`prod_q[22:0]`, e+=1.
  - Otherwise: mant=`prod_q[45:23]`, guard=`prod_q[22]`, sticky=|`prod_q[21:0]`.
- **Normal path: round to nearest-even.**
  - Round up when guard && (sticky || mant[0]).
  - If rounding carries out of mant: mant=0, e+=1.
  - inexact = guard|sticky.
- **Normal path: range checks.**
  - e ≥ 255 → sign|0x7F800000, overflow=1, inexact=1.
  - e ≤ 0 → sign|0, underflow=1, inexact=1. No denormal outputs.
- **Output stability.** `out_result`/`out_flags` stay stable while `out_valid`=1 and `out_ready`=0.

## Timing
- **Reset values.** During `rst` and on the cycle after it:
  - state=IDLE, counter=0, `out_valid`=0, `out_result`=0, `out_flags`=0, `busy`=0.
  - `in_ready`=0 while `rst`=1.
- **Reset mid-operation.** Any state aborts with no output. The in-flight operation is discarded.
- **Latency, accept cycle t.**
  - Normal path: `out_valid` rises at t+SETTLE_CYCLES+2.
  - Special path: `out_valid` rises at t+1.
- **Throughput.** Best case is one op per SETTLE_CYCLES+3 cycles (normal) or per 2 cycles (special).
- **Operand hold.** The registered operands feed `fp_multiplier` and are unchanged from the accept edge until `prod_q` is captured. The array path is a multicycle path of SETTLE_CYCLES.
- **Output ports.** `out_valid`, `out_result` and `out_flags` are register outputs. `in_ready` and `busy` are decoded from state.

## Structure
- Package `fp_mul_pkg` holds:
  - the state encoding;
  - BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, INF_MAG=32'h7F800000;
  - flag bit indices: INVALID=3, OVERFLOW=2, UNDERFLOW=1, INEXACT=0.
- Single sub-module: one `fp_multiplier` instance (existing, 48-bit raw mantissa output), fed from the operand registers. Normalize and round logic stays inline in the ROUND stage.

## Test plan
- **Basic latency.** SETTLE_CYCLES=2: 0x3FC00000 × 0x40000000 → 0x40400000, flags 0, `out_valid` exactly 4 cycles after accept.
- **Normalize shift path.** 0x3FC00000 × 0x3FC00000 → 0x40100000, flags 0 (exercises the `prod_q[47]`=1 path).
- **Rounding.** 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1, others 0.
- **Overflow / underflow.**
  - 0x7F000000 × 0x40000000 → 0x7F800000, flags 4'b0101.
  - 0x00800000 × 0x3F000000 → 0x00000000, flags 4'b0011.
- **Special path with backpressure.** 0x7F800000 × 0x00000000 → 0x7FC00000, flags 4'b1000, `out_valid` 1 cycle after accept. Hold `out_ready`=0 for 5 cycles: result stable, `in_ready`=0, then IDLE one cycle after `out_ready`.
- **Reset mid-operation.** Assert `rst` during SETTLE → `out_valid` never rises for that op. `in_ready`=1 the cycle after `rst` deasserts. The next op 0x40000000 × 0x40000000 → 0x40800000.
